// File: rtl/scope_trigger_capture.sv
// Sample-strobed scope capture: circular pre-trigger history, slope/level trigger, DEPTH-sample window, time-ordered readback (1-cycle rd_data).
// No backpressure: every qualified sample is stored. Optional timeout-forced trigger under macro AUTO_TRIG_EN.
module scope_trigger_capture #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 10,
  parameter int PRE_TRIG     = 256,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              fast_clk,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic              auto_trig
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  PRE_CNT  = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  POST_CNT = CNT_W'(DEPTH - PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_OFF  = ADDR_W'(PRE_TRIG);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRETRIG = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 1) begin : g_bad_pre_trig
    $error("scope_trigger_capture: PRE_TRIG out of range");
  end
  if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
    $error("scope_trigger_capture: AUTO_TIMEOUT must be >= 1");
  end

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic              triggered_q, triggered_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              store;
  logic [CNT_W-1:0]  cnt_inc;
  logic              rise_hit, fall_hit, real_trig, auto_fire, fire;
  logic [ADDR_W-1:0] rd_idx;

  assign store   = sample_en && (state_q == S_PRETRIG || state_q == S_ARMED || state_q == S_POST);
  assign cnt_inc = cnt_q + 1'b1;

  assign rise_hit  = (prev_q < trig_level) && (sample_in >= trig_level);
  assign fall_hit  = (prev_q > trig_level) && (sample_in <= trig_level);
  assign real_trig = store && (state_q == S_ARMED) && prev_vld_q && (trig_slope ? fall_hit : rise_hit);
  assign fire      = real_trig || auto_fire;

`ifdef AUTO_TRIG_EN
  localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);

  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic              auto_trig_q, auto_trig_d;

  // A real crossing on the timeout sample wins, so auto_fire excludes it.
  assign auto_fire = store && (state_q == S_ARMED) && !real_trig && (auto_cnt_q == AUTO_LAST);

  always_comb begin
    auto_cnt_d  = auto_cnt_q;
    auto_trig_d = auto_trig_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && arm) begin
      auto_cnt_d  = '0;
      auto_trig_d = 1'b0;
    end else if (state_q == S_PRETRIG) begin
      auto_cnt_d = '0;
    end else if (state_q == S_ARMED && store) begin
      auto_cnt_d = auto_cnt_q + 1'b1;
      if (auto_fire) auto_trig_d = 1'b1;
    end
  end

  always_ff @(posedge fast_clk) begin
    if (!reset_n) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  assign auto_trig = auto_trig_q;
`else
  assign auto_fire = 1'b0;
  assign auto_trig = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    triggered_d = triggered_q;

    if (store) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      prev_d     = sample_in;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d     = S_PRETRIG;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          triggered_d = 1'b0;
          prev_vld_d  = 1'b0;
        end
      end
      S_PRETRIG: begin
        if (store) begin
          cnt_d = cnt_inc;
          if (cnt_inc == PRE_CNT) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end
        end
      end
      S_ARMED: begin
        // wr_ptr_q is the slot the trigger sample lands in this cycle.
        if (fire) begin
          start_ptr_d = wr_ptr_q - PRE_OFF;
          triggered_d = 1'b1;
          cnt_d       = CNT_W'(1);
          state_d     = (POST_CNT == CNT_W'(1)) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (store) begin
          cnt_d = cnt_inc;
          if (cnt_inc == POST_CNT) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      triggered_q <= triggered_d;
    end
  end

  // Capture RAM keeps its contents across reset; only the session state clears.
  always_ff @(posedge fast_clk) begin
    if (reset_n && store) mem[wr_ptr_q] <= sample_in;
  end

  assign rd_idx = start_ptr_q + rd_addr;

  always_ff @(posedge fast_clk) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= mem[rd_idx];
  end

  assign rd_data   = rd_data_q;
  assign busy      = (state_q == S_PRETRIG) || (state_q == S_ARMED) || (state_q == S_POST);
  assign triggered = triggered_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture with ADDR_W=4, PRE_TRIG=4, AUTO_TIMEOUT=8.
module tb_scope_trigger_capture;

  logic        fast_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] sample_in = '0;
  logic        arm = 1'b0;
  logic [11:0] trig_level = 12'h800;
  logic        trig_slope = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [11:0] rd_data;
  logic        busy, triggered, done, auto_trig;

  int n_checks = 0;
  int n_errors = 0;

  scope_trigger_capture #(
    .DATA_W(12), .ADDR_W(4), .PRE_TRIG(4), .AUTO_TIMEOUT(8)
  ) dut (
    .fast_clk(fast_clk), .reset_n(reset_n), .sample_en(sample_en), .sample_in(sample_in),
    .arm(arm), .trig_level(trig_level), .trig_slope(trig_slope), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .triggered(triggered), .done(done), .auto_trig(auto_trig)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [11:0] v);
    @(negedge fast_clk);
    sample_en = 1'b1;
    sample_in = v;
    @(negedge fast_clk);
    sample_en = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [11:0] base);
    for (int i = 0; i < n; i++) send(base + 12'(i));
  endtask

  task automatic send_const(input int n, input logic [11:0] v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic do_arm;
    @(negedge fast_clk);
    arm = 1'b1;
    @(negedge fast_clk);
    arm = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [11:0] exp);
    @(negedge fast_clk);
    rd_addr = a;
    @(negedge fast_clk);
    check(tag, rd_data, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge fast_clk);
    check("rst_busy", busy, 0);
    check("rst_trig", triggered, 0);
    check("rst_done", done, 0);
    check("rst_auto", auto_trig, 0);
    check("rst_rd", rd_data, 0);
    reset_n = 1'b1;

    // Rising trigger: trigger lands at slot 6, window starts at slot 2
    trig_level = 12'h800; trig_slope = 1'b0;
    do_arm();
    check("rise_busy_arm", busy, 1);
    send_const(6, 12'h100);
    check("rise_notrig", triggered, 0);
    send(12'h900);
    check("rise_trig", triggered, 1);
    send_n(10, 12'h901);
    check("rise_notdone", done, 0);
    send(12'h90B);
    check("rise_done", done, 1);
    check("rise_busy_done", busy, 0);
    rd_chk("rise_w0", 4'd0, 12'h100);
    rd_chk("rise_w3", 4'd3, 12'h100);
    rd_chk("rise_w4", 4'd4, 12'h900);
    rd_chk("rise_w5", 4'd5, 12'h901);
    rd_chk("rise_w14", 4'd14, 12'h90A);
    rd_chk("rise_w15", 4'd15, 12'h90B);

    // Reset mid-POST
    do_arm();
    check("rearm_trig_clr", triggered, 0);
    send_n(4, 12'h100);
    send(12'h900);
    send_n(2, 12'h901);
    check("midpost_busy", busy, 1);
    rd_addr = 4'd4;
    @(negedge fast_clk);
    reset_n = 1'b0;
    @(negedge fast_clk);
    check("midrst_busy", busy, 0);
    check("midrst_trig", triggered, 0);
    check("midrst_done", done, 0);
    check("midrst_rd", rd_data, 0);
    reset_n = 1'b1;
    @(negedge fast_clk);
    check("midrst_idle", busy, 0);

    // Falling trigger: 0xEAE stays above level, 0x123 crosses
    trig_slope = 1'b1;
    do_arm();
    check("fall_busy", busy, 1);
    send_const(5, 12'hEFF);
    send(12'hEAE);
    check("fall_eae_notrig", triggered, 0);
    send(12'h123);
    check("fall_trig", triggered, 1);
    send_n(11, 12'h200);
    check("fall_done", done, 1);
    rd_chk("fall_w0", 4'd0, 12'hEFF);
    rd_chk("fall_w3", 4'd3, 12'hEAE);
    rd_chk("fall_w4", 4'd4, 12'h123);

    // Crossing inside the pre-trigger fill is ignored
    trig_slope = 1'b0;
    do_arm();
    send(12'h100); send(12'h900); send(12'h100); send(12'h100);
    check("mask_notrig", triggered, 0);
    send(12'h100);
    check("mask_armed_notrig", triggered, 0);
    send(12'h900);
    check("mask_trig", triggered, 1);
    send_n(11, 12'h300);
    check("mask_done", done, 1);

    // History wrap: trigger at slot 2, window starts at slot 14
    do_arm();
    send_n(4, 12'h010);
    send_n(30, 12'h020);
    check("wrap_notrig", triggered, 0);
    send(12'h900);
    check("wrap_trig", triggered, 1);
    send_n(11, 12'h300);
    check("wrap_done", done, 1);
    rd_chk("wrap_w0", 4'd0, 12'h03A);
    rd_chk("wrap_w1", 4'd1, 12'h03B);
    rd_chk("wrap_w2", 4'd2, 12'h03C);
    rd_chk("wrap_w3", 4'd3, 12'h03D);
    rd_addr = 4'd4;
    #1;
    check("wrap_lat_hold", rd_data, 12'h03D);
    @(negedge fast_clk);
    check("wrap_lat_new", rd_data, 12'h900);

    // Sample coincident with arm is dropped
    @(negedge fast_clk);
    arm = 1'b1; sample_en = 1'b1; sample_in = 12'hFFF;
    @(negedge fast_clk);
    arm = 1'b0; sample_en = 1'b0;
    send_n(4, 12'h050);
    send(12'h900);
    send_n(11, 12'h300);
    check("same_done", done, 1);
    rd_chk("same_w0", 4'd0, 12'h050);
    rd_chk("same_w4", 4'd4, 12'h900);

    // Constant input never crosses; only the timeout can trigger
    do_arm();
    send_const(4, 12'hAAA);
    send_const(7, 12'hAAA);
    check("auto_7_notrig", triggered, 0);
    send(12'hAAA);
`ifdef AUTO_TRIG_EN
    check("auto_8_trig", triggered, 1);
    check("auto_flag", auto_trig, 1);
    send_n(11, 12'h400);
    check("auto_done", done, 1);
    rd_chk("auto_w4", 4'd4, 12'hAAA);
    do_arm();
    check("auto_flag_clr", auto_trig, 0);
`else
    check("noauto_trig", triggered, 0);
    check("noauto_flag", auto_trig, 0);
    check("noauto_busy", busy, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
